datapath_seq: RTL
=================

Name: datapath_seq

Overview:
- Parametrised, self-sequencing successor to the single-bus datapath.
- Contains:
  - NREGS x WIDTH register file
  - Y operand register
  - 2*WIDTH Z register
  - HI and LO registers
  - ALU
- An internal one-hot bus multiplexer is driven by a built-in T-state controller. The CPU control unit therefore issues one start request per register-to-register operation, instead of strobing individual read/write enables.
- Sits between the future control unit and the memory/IO blocks. The external load port is the path for MDR/inport data.

Parameters:
- WIDTH, 32, data/bus width in bits (>=8, power of two)
- NREGS, 16, number of general registers (>=2, power of two)
- RW, $clog2(NREGS), register index width (derived; do not override)

Ports:
- clk  in  1  clock, rising edge
- clr  in  1  asynchronous active-high reset
- in_start  in  1  request an operation; sampled only in IDLE
- in_opcode  in  4  ALU operation
- in_src_a  in  RW  operand A register index
- in_src_b  in  RW  operand B register index
- in_dst  in  RW  destination register index
- in_load  in  1  write in_load_data into register in_load_dst; honoured only in IDLE
- in_load_dst  in  RW  load destination index
- in_load_data  in  WIDTH  load data
- out_busy  out  1  operation in progress
- out_done  out  1  one-cycle pulse, operation complete
- out_err  out  1  one-cycle pulse, illegal opcode rejected
- out_bus  out  WIDTH  current bus value (debug/monitor)
- out_hi  out  WIDTH  HI register
- out_lo  out  WIDTH  LO register

Behaviour:
- Reset (clr=1, async):
  - all registers, Y, Z, HI and LO = 0
  - state = IDLE
  - out_busy, out_done, out_err = 0
  - out_bus = 0
- Reset mid-operation aborts immediately. No partial write survives: registers clear.
- States: IDLE, TA, TB, TWLO, TWHI.
- IDLE:
  - Bus = in_load_data if in_load, else 0.
  - in_start=1 with legal opcode (0-11): latch opcode/src_a/src_b/dst, go to TA. Any simultaneous in_load is dropped.
  - in_start=1 with opcode 12-15: stay IDLE, out_err=1 next cycle, no register change.
  - in_load=1 without start: reg[in_load_dst] <= in_load_data at this edge.
- TA: bus = reg[src_a]; Y <= bus; go to TB.
- TB: bus = reg[src_b]; Z <= ALU(Y, bus); go to TWLO.
- TWLO: bus = Z[WIDTH-1:0]; reg[dst] <= bus; LO <= bus; go to TWHI if opcode=MUL, else IDLE.
- TWHI: bus = Z[2W-1:W]; HI <= bus; go to IDLE.
- out_busy = 1 exactly in TA/TB/TWLO/TWHI.
- out_done is registered, high for the one cycle after the final write, i.e. the first IDLE cycle.
- A new in_start in that same cycle is accepted (back-to-back).
- Latency from start-sampling edge to done high: 4 cycles for non-MUL, 5 cycles for MUL.
- Operand latching: src/dst indices are latched, so input changes while busy have no effect. in_start and in_load while busy are ignored.
- dst equal to src_a or src_b is legal. Operands are read before the write (TA/TB precede TWLO).
- ALU, a = Y, b = bus:
  - Result fits WIDTH unless noted.
  - Z high half = 0 except for MUL.
  - Opcodes:
    - 0 ADD: a+b, mod 2^W
    - 1 SUB: a-b, mod 2^W
    - 2 AND
    - 3 OR
    - 4 XOR
    - 5 NOT: ~b
    - 6 SHL: a << b[log2W-1:0]
    - 7 SHR: logical
    - 8 SHRA: arithmetic
    - 9 MUL: signed a*b, full 2W result
    - 10 NEG: -b
    - 11 MOV: b
  - Shift amounts use only the low log2(WIDTH) bits of b.
- Bus is driven by exactly one source per state via internal one-hot select. No X is ever driven; unused cycles drive 0.

Test Plan (WIDTH=32, NREGS=16):
- Reset: assert clr mid-TB of an ADD -> all outputs 0 and state IDLE within the same cycle; after release, a fresh op completes normally.
- Load + ADD:
  - Setup: load r1=0x0000_0005, r2=0xFFFF_FFFF; start ADD a=1 b=2 dst=3.
  - Required: out_busy high 3 cycles; out_done pulse on cycle 4; r3 = out_lo = 0x0000_0004; out_hi unchanged.
- Signed MUL:
  - Setup: r1=0xFFFF_FFFE (-2), r2=0x0000_0003.
  - Required: busy 4 cycles; done on cycle 5; out_lo=0xFFFF_FFFA, out_hi=0xFFFF_FFFF; r4=0xFFFF_FFFA.
- Shifts:
  - Setup: r1=0x8000_0000, r2=0x0000_0024 (amount 4).
  - Required: SHRA gives 0xF800_0000; SHR gives 0x0800_0000; SHL gives 0x0000_0000.
- Illegal opcode and collisions:
  - Start with opcode 13 -> out_err one cycle, no busy, no register change.
  - Start+load same cycle -> load dropped.
  - Start while busy -> ignored.
- Back-to-back with aliasing:
  - Op1: SUB dst=1 a=1 b=2 with r1=10, r2=3 -> r1=7.
  - Op2: start in the done cycle, ADD dst=5 a=1 b=1 -> r5=14.
  - out_bus traces r1, r2, Z lo in the expected cycles.

Source files
------------

// File: rtl/datapath_seq.sv
// Self-sequencing single-bus datapath: register file, Y/Z/HI/LO and ALU, stepped through
// TA/TB/TWLO/TWHI by an internal controller after a single start request.
module datapath_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 16,
  parameter int unsigned RW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_start,
  input  logic [3:0]       in_opcode,
  input  logic [RW-1:0]    in_src_a,
  input  logic [RW-1:0]    in_src_b,
  input  logic [RW-1:0]    in_dst,
  input  logic             in_load,
  input  logic [RW-1:0]    in_load_dst,
  input  logic [WIDTH-1:0] in_load_data,
  output logic             out_busy,
  output logic             out_done,
  output logic             out_err,
  output logic [WIDTH-1:0] out_bus,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo
);

  localparam int unsigned SW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpNot  = 4'd5;
  localparam logic [3:0] OpShl  = 4'd6;
  localparam logic [3:0] OpShr  = 4'd7;
  localparam logic [3:0] OpShra = 4'd8;
  localparam logic [3:0] OpMul  = 4'd9;
  localparam logic [3:0] OpNeg  = 4'd10;
  localparam logic [3:0] OpMov  = 4'd11;

  typedef enum logic [2:0] {StIdle, StTa, StTb, StTwlo, StTwhi} state_e;

  state_e             state_q, state_d;
  logic [3:0]         op_q;
  logic [RW-1:0]      src_a_q, src_b_q, dst_q;
  logic [WIDTH-1:0]   y_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] z_q;
  logic               done_q, err_q;
  logic [WIDTH-1:0]   regs_q [NREGS];

  logic               start_ok;
  logic [4:0]         bus_sel;
  logic [WIDTH-1:0]   bus;
  logic [WIDTH-1:0]   alu_res;
  logic [2*WIDTH-1:0] mul_full, alu_z;

  assign start_ok = in_start && (in_opcode < 4'd12);

  // One-hot bus select: load port, reg[src_a], reg[src_b], Z low, Z high.
  always_comb begin
    bus_sel = '0;
    if (!clr) begin
      unique case (state_q)
        StIdle:  bus_sel[0] = in_load;
        StTa:    bus_sel[1] = 1'b1;
        StTb:    bus_sel[2] = 1'b1;
        StTwlo:  bus_sel[3] = 1'b1;
        StTwhi:  bus_sel[4] = 1'b1;
        default: bus_sel    = '0;
      endcase
    end
  end

  assign bus = ({WIDTH{bus_sel[0]}} & in_load_data)
             | ({WIDTH{bus_sel[1]}} & regs_q[src_a_q])
             | ({WIDTH{bus_sel[2]}} & regs_q[src_b_q])
             | ({WIDTH{bus_sel[3]}} & z_q[WIDTH-1:0])
             | ({WIDTH{bus_sel[4]}} & z_q[2*WIDTH-1:WIDTH]);

  // Sign-extend both operands to 2W so the unsigned product equals the signed one.
  assign mul_full = {{WIDTH{y_q[WIDTH-1]}}, y_q} * {{WIDTH{bus[WIDTH-1]}}, bus};

  always_comb begin
    alu_res = '0;
    case (op_q)
      OpAdd:   alu_res = y_q + bus;
      OpSub:   alu_res = y_q - bus;
      OpAnd:   alu_res = y_q & bus;
      OpOr:    alu_res = y_q | bus;
      OpXor:   alu_res = y_q ^ bus;
      OpNot:   alu_res = ~bus;
      OpShl:   alu_res = y_q << bus[SW-1:0];
      OpShr:   alu_res = y_q >> bus[SW-1:0];
      OpShra:  alu_res = $signed(y_q) >>> bus[SW-1:0];
      OpNeg:   alu_res = {WIDTH{1'b0}} - bus;
      OpMov:   alu_res = bus;
      default: alu_res = '0;
    endcase
    alu_z = (op_q == OpMul) ? mul_full : {{WIDTH{1'b0}}, alu_res};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StTa;
      StTa:    state_d = StTb;
      StTb:    state_d = StTwlo;
      StTwlo:  state_d = (op_q == OpMul) ? StTwhi : StIdle;
      StTwhi:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      op_q    <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      y_q     <= '0;
      z_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= ((state_q == StTwlo) && (op_q != OpMul)) || (state_q == StTwhi);
      err_q   <= (state_q == StIdle) && in_start && !start_ok;
      unique case (state_q)
        StIdle: begin
          // A start request, legal or not, takes priority and drops any load.
          if (start_ok) begin
            op_q    <= in_opcode;
            src_a_q <= in_src_a;
            src_b_q <= in_src_b;
            dst_q   <= in_dst;
          end else if (in_load && !in_start) begin
            regs_q[in_load_dst] <= in_load_data;
          end
        end
        StTa:   y_q <= bus;
        StTb:   z_q <= alu_z;
        StTwlo: begin
          regs_q[dst_q] <= bus;
          lo_q          <= bus;
        end
        StTwhi: hi_q <= bus;
        default: ;
      endcase
    end
  end

  assign out_busy = (state_q != StIdle);
  assign out_done = done_q;
  assign out_err  = err_q;
  assign out_bus  = bus;
  assign out_hi   = hi_q;
  assign out_lo   = lo_q;

endmodule
